// File: rtl/fw_meta_reporter_if.sv
// Byte-stream and arbitration signals between the version-record reporter
// and its two requesters / downstream sink.
interface fw_meta_reporter_if;
  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] done;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    input  req, out_ready,
    output grant, done, out_data, out_valid, out_last
  );

  modport slave (
    output req, out_ready,
    input  grant, done, out_data, out_valid, out_last
  );
endinterface

// File: rtl/fw_meta_reporter.sv
// Two-way round-robin arbiter that streams a 5-byte firmware version packet
// (magic, major, minor, patch, xor checksum) from a snapshot taken at grant.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no packet in flight; arbitrate and snapshot on any request
// SEND  | streaming packet bytes to the granted requester's sink
module fw_meta_reporter #(
  parameter logic [7:0] HDR_MAGIC = 8'hA5
) (
  input  logic               clk,
  input  logic               rst_n,
  fw_meta_reporter_if.master bus,
  input  logic [7:0]         ver_major,
  input  logic [7:0]         ver_minor,
  input  logic [7:0]         ver_patch,
  output logic               busy
);

  localparam int         PKT_LEN  = 5;
  localparam logic [2:0] LAST_IDX = 3'(PKT_LEN - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] maj_q, maj_d, min_q, min_d, pat_q, pat_d;
  logic [7:0] data_q, data_d;
  logic       last_q, last_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] done_q, done_d;
  logic       last_grant_q, last_grant_d;
  logic       pick;
  logic       hs;

  function automatic logic [7:0] pkt_byte(input logic [2:0] i, input logic [7:0] ma,
                                          input logic [7:0] mi, input logic [7:0] pa);
    case (i)
      3'd0:    pkt_byte = HDR_MAGIC;
      3'd1:    pkt_byte = ma;
      3'd2:    pkt_byte = mi;
      3'd3:    pkt_byte = pa;
      default: pkt_byte = HDR_MAGIC ^ ma ^ mi ^ pa;
    endcase
  endfunction

  assign hs = (state_q == SEND) && bus.out_ready;

  // Tie goes to whoever was not served last.
  always_comb begin
    pick = 1'b0;
    case (bus.req)
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_grant_q;
      default: pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      maj_q        <= '0;
      min_q        <= '0;
      pat_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      maj_q        <= maj_d;
      min_q        <= min_d;
      pat_q        <= pat_d;
      data_q       <= data_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req != 2'b00) state_d = SEND;
      SEND:    if (hs && idx_q == LAST_IDX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d        = idx_q;
    maj_d        = maj_q;
    min_d        = min_q;
    pat_d        = pat_q;
    data_d       = data_q;
    last_d       = last_q;
    grant_d      = grant_q;
    done_d       = 2'b00;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          grant_d      = pick ? 2'b10 : 2'b01;
          last_grant_d = pick;
          maj_d        = ver_major;
          min_d        = ver_minor;
          pat_d        = ver_patch;
          idx_d        = '0;
          data_d       = HDR_MAGIC;
          last_d       = 1'b0;
        end
      end
      SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            done_d  = grant_q;
            grant_d = 2'b00;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_q + 3'd1;
            data_d = pkt_byte(idx_q + 3'd1, maj_q, min_q, pat_q);
            last_d = (idx_q + 3'd1) == LAST_IDX;
          end
        end
      end
      default: ;
    endcase
  end

  assign busy          = (state_q == SEND);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;
  assign bus.grant     = grant_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fw_meta_reporter.sv
// Directed bench for fw_meta_reporter: single packet, backpressure, snapshot,
// early request drop, mid-packet reset and round-robin alternation.
module tb_fw_meta_reporter;
  logic       clk;
  logic       rst_n;
  logic [7:0] ver_major, ver_minor, ver_patch;
  logic       busy;
  int         n_checks;
  int         n_errors;

  fw_meta_reporter_if bus ();

  fw_meta_reporter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.master),
    .ver_major (ver_major),
    .ver_minor (ver_minor),
    .ver_patch (ver_patch),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the first packet byte visible. After byte 0 is accepted,
  // req and ver_minor are set to req_a0/min_a0. Ends on the idle cycle.
  task automatic expect_pkt(input string tag, input logic [1:0] g, input logic [39:0] bytes,
                            input int stall_idx, input int stall_n,
                            input logic [1:0] req_a0, input logic [7:0] min_a0);
    logic [7:0] b;
    chk({tag, " grant"}, bus.grant, g);
    chk({tag, " busy"}, busy, 1'b1);
    chk({tag, " done idle"}, bus.done, 2'b00);
    for (int i = 0; i < 5; i++) begin
      b = bytes[39 - 8*i -: 8];
      if (i == stall_idx) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          chk($sformatf("%s hold%0d", tag, k), bus.out_data, b);
          chk($sformatf("%s hold valid%0d", tag, k), bus.out_valid, 1'b1);
          step();
        end
        bus.out_ready = 1'b1;
      end
      chk($sformatf("%s byte%0d", tag, i), bus.out_data, b);
      chk($sformatf("%s valid%0d", tag, i), bus.out_valid, 1'b1);
      chk($sformatf("%s last%0d", tag, i), bus.out_last, (i == 4));
      chk($sformatf("%s grant%0d", tag, i), bus.grant, g);
      step();
      if (i == 0) begin
        bus.req   = req_a0;
        ver_minor = min_a0;
      end
    end
    chk({tag, " done"}, bus.done, g);
    chk({tag, " end valid"}, bus.out_valid, 1'b0);
    chk({tag, " end last"}, bus.out_last, 1'b0);
    chk({tag, " end grant"}, bus.grant, 2'b00);
    chk({tag, " end busy"}, busy, 1'b0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.req       = 2'b00;
    bus.out_ready = 1'b1;
    ver_major     = 8'h0B;
    ver_minor     = 8'h01;
    ver_patch     = 8'h00;
    step();
    step();
    chk("rst grant", bus.grant, 2'b00);
    chk("rst done", bus.done, 2'b00);
    chk("rst valid", bus.out_valid, 1'b0);
    chk("rst last", bus.out_last, 1'b0);
    chk("rst data", bus.out_data, 8'h00);
    chk("rst busy", busy, 1'b0);
    rst_n = 1'b1;
    step();
    chk("idle valid", bus.out_valid, 1'b0);

    // single one-cycle request
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    expect_pkt("single", 2'b01, 40'hA5_0B_01_00_AF, 9, 0, 2'b00, 8'h01);
    step();
    chk("single done clr", bus.done, 2'b00);
    chk("single stay idle", busy, 1'b0);

    // backpressure at index 2 for 3 cycles
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    expect_pkt("bp", 2'b01, 40'hA5_0B_01_00_AF, 2, 3, 2'b00, 8'h01);
    step();

    // snapshot: minor changes after byte 0, held req gives back-to-back packet
    bus.req = 2'b01;
    step();
    expect_pkt("snap1", 2'b01, 40'hA5_0B_01_00_AF, 9, 0, 2'b01, 8'h07);
    step();
    expect_pkt("snap2", 2'b01, 40'hA5_0B_07_00_A9, 9, 0, 2'b00, 8'h07);
    step();
    chk("snap idle", bus.out_valid, 1'b0);

    // early drop of req after byte 0
    bus.req = 2'b01;
    step();
    expect_pkt("drop", 2'b01, 40'hA5_0B_07_00_A9, 9, 0, 2'b00, 8'h07);
    step();
    chk("drop idle grant", bus.grant, 2'b00);
    chk("drop idle busy", busy, 1'b0);

    // reset mid-packet after byte 2 handshake
    bus.req = 2'b01;
    step();
    bus.req = 2'b00;
    for (int i = 0; i < 3; i++) step();
    chk("mid data idx3", bus.out_data, 8'h00);
    chk("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid rst valid", bus.out_valid, 1'b0);
    chk("mid rst grant", bus.grant, 2'b00);
    chk("mid rst busy", busy, 1'b0);
    chk("mid rst last", bus.out_last, 1'b0);
    step();
    chk("mid rst done", bus.done, 2'b00);
    rst_n = 1'b1;
    bus.req = 2'b11;
    step();
    chk("post rst done", bus.done, 2'b00);

    // tie and alternation, req held
    expect_pkt("tie0", 2'b01, 40'hA5_0B_07_00_A9, 9, 0, 2'b11, 8'h07);
    step();
    expect_pkt("tie1", 2'b10, 40'hA5_0B_07_00_A9, 9, 0, 2'b11, 8'h07);
    step();
    expect_pkt("tie2", 2'b01, 40'hA5_0B_07_00_A9, 9, 0, 2'b00, 8'h07);
    step();
    chk("tie final idle", busy, 1'b0);
    chk("tie final done", bus.done, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
